// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, MMIO address
// and the default bit period.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with occupancy count; rd_data shows the head entry
// combinationally so a pop and its data land on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write at full still fits when the head leaves on the same edge
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: MMIO byte stores queue in a FIFO and are
// serialized back-to-back on uart_tx.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   uart_tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t          state;
  state_t          state_n;
  logic [BW-1:0]   baud_cnt;
  logic [BW-1:0]   baud_n;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_n;
  logic [7:0]      shift;
  logic [7:0]      shift_n;
  logic            tx_reg;
  logic            tx_n;
  logic            pop;
  logic            baud_end;
  logic [7:0]      head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign busy     = (state != IDLE);
  assign uart_tx  = tx_reg;

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_reg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!empty) begin
          state_n = START;
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Chain straight into the next start bit so frames have no gap
          if (!empty) begin
            state_n = START;
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_reg   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      tx_reg   <= tx_n;
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Payload register carries no control meaning, so it is left out of reset
  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       busy;
  logic       overflow;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  bit         ok_q[$];
  int         start_q[$];

  int         cyc = 0;
  bit         mon_active = 1'b0;
  int         mon_cyc = 0;
  bit         mon_ok = 1'b1;
  logic [7:0] mon_byte = 8'h00;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .overflow (overflow),
    .uart_tx  (uart_tx)
  );

  // Line decoder: samples mid-bit on the falling edge, drops a frame cut by reset
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (uart_tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
          mon_ok     = 1'b1;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cyc++;
        if (mon_cyc == 2 && uart_tx !== 1'b0) mon_ok = 1'b0;
        if (mon_cyc >= 6 && mon_cyc <= 34 && ((mon_cyc - 6) % 4) == 0)
          mon_byte[(mon_cyc - 6) / 4] = uart_tx;
        if (mon_cyc == 38 && uart_tx !== 1'b1) mon_ok = 1'b0;
        if (mon_cyc == 39) begin
          rx_q.push_back(mon_byte);
          ok_q.push_back(mon_ok);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    wr_en = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    rx_q.delete();
    ok_q.delete();
    start_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int limit);
    int c;
    c = 0;
    while (rx_q.size() < n && c < limit) begin
      tick();
      c++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL frame_timeout got %0d frames required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", uart_tx); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b required 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b required 0", full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d required 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", overflow); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame10;
    frame10 = {1'b1, 8'h55, 1'b0};
    do_reset(2);
    write_byte(8'h55);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_tx_after_write got %b required 1", uart_tx); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write got %b required 0", empty); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_after_write got %0d required 1", count); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_pop got %b required 1", busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b required 1", empty); end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (uart_tx !== frame10[k / 4]) begin
        errors++;
        $display("FAIL single_line_cycle%0d got %b required %b", k, uart_tx, frame10[k / 4]);
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b required 0", busy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end got %b required 1", empty); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got %b required 1", uart_tx); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_decoded got %0d frames first %h required 1 frame 55", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    write_byte(8'hA3);
    write_byte(8'h0F);
    wait_frames(2, 300);
    if (rx_q.size() >= 2) begin
      checks++; if (rx_q[0] !== 8'hA3) begin errors++; $display("FAIL b2b_byte0 got %h required a3", rx_q[0]); end
      checks++; if (rx_q[1] !== 8'h0F) begin errors++; $display("FAIL b2b_byte1 got %h required 0f", rx_q[1]); end
      checks++; if (!(ok_q[0] && ok_q[1])) begin errors++; $display("FAIL b2b_framing got %b%b required 11", ok_q[0], ok_q[1]); end
      checks++;
      if (start_q[1] - start_q[0] != 40) begin
        errors++;
        $display("FAIL b2b_gap got %0d cycles between starts required 40", start_q[1] - start_q[0]);
      end
    end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_end got %b required 1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_reset(2);
    for (int i = 0; i < 5; i++) write_byte(bytes[i]);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b required 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_full got %0d required 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b required 0", overflow); end
    write_byte(bytes[5]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_drop got %0d required 4", count); end
    wait_frames(5, 400);
    repeat (80) tick();
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_frame_count got %0d required 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) begin
        checks++;
        if (rx_q[i] !== bytes[i] || !ok_q[i]) begin
          errors++;
          $display("FAIL ovf_byte%0d got %h ok %b required %h ok 1", i, rx_q[i], ok_q[i], bytes[i]);
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_still_set got %b required 1", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got %b required 0", busy); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] bytes [6];
    bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_reset(2);
    for (int i = 0; i < 5; i++) write_byte(bytes[i]);
    repeat (36) tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fwp_count_before got %0d required 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fwp_full_before got %b required 1", full); end
    write_byte(bytes[5]);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fwp_count_after got %0d required 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fwp_overflow got %b required 0", overflow); end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL fwp_next_start got %b required 0", uart_tx); end
    wait_frames(6, 400);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_q.size()) begin
        checks++;
        if (rx_q[i] !== bytes[i] || !ok_q[i]) begin
          errors++;
          $display("FAIL fwp_byte%0d got %h ok %b required %h ok 1", i, rx_q[i], ok_q[i], bytes[i]);
        end
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fwp_overflow_end got %b required 0", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    bit went_low;
    do_reset(2);
    write_byte(8'hF7);
    write_byte(8'h12);
    write_byte(8'h34);
    repeat (15) tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL midrst_count_before got %0d required 2", count); end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midrst_bit3 got %b required 0", uart_tx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b required 1", uart_tx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d required 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy); end
    went_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx !== 1'b1) went_low = 1'b1;
      tick();
    end
    checks++; if (went_low) begin errors++; $display("FAIL midrst_quiet got line low required high"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_frames got %0d required 0", rx_q.size()); end
    write_byte(8'h5A);
    wait_frames(1, 100);
    if (rx_q.size() >= 1) begin
      checks++; if (rx_q[0] !== 8'h5A) begin errors++; $display("FAIL midrst_recover got %h required 5a", rx_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that consumes byte stores the memory-access stage makes to the UART MMIO address. Accepted bytes go into a FIFO and are serialized as 8N1 frames on `uart_tx`. The `full` output lets the memory-access stage stall a store instead of losing a byte. The block sits directly downstream of the memory-access stage and replaces the unbuffered UART path at the top level.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — clk cycles per serial bit (50 MHz / 115200); must be ≥ 2.
- `DEPTH`, default 16 — FIFO entries; must be a power of two, ≥ 2.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `wr_en`  in  1  store to the UART address this cycle.
- `wr_data`  in  8  byte to transmit (store data [7:0]).
- `full`  out  1  FIFO holds `DEPTH` entries; the memory-access stage stalls the store while high.
- `empty`  out  1  FIFO holds no entries.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `overflow`  out  1  sticky; set when a write is dropped; cleared only by `rst`.
- `uart_tx`  out  1  serial line, idle high.

## Operation
- FIFO write accepted when `wr_en && (!full || pop)`, where `pop` is the same-cycle FSM read. `wr_en && full && !pop` drops the byte and sets `overflow`.
- `count` +1 on write only, −1 on pop only, unchanged on simultaneous write+pop. Pointers are $clog2(DEPTH) bits and wrap naturally.
- FSM states:
  - IDLE: `uart_tx`=1.
  - START: `uart_tx`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `uart_tx`=1.
- Transitions:
  - IDLE → START when `!empty`; the FIFO head is popped into the shift register on that edge.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8×`CLKS_PER_BIT` cycles; the bit index counts 0..7.
  - STOP → START (with pop) if `!empty` when the stop bit ends, else STOP → IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`−1 and resets to 0 on every state or bit change.
- `uart_tx` is driven from a register; there is no combinational path from inputs.

## Timing
- Reset values: `uart_tx`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0, state=IDLE, pointers=0. FIFO contents are don't-care.
- Reset mid-frame: `uart_tx` returns to 1 at the reset edge and queued bytes are discarded.
- Write latency: a write at edge N into an empty FIFO with FSM in IDLE makes `empty`=0 after edge N. The pop happens at edge N+1, and `uart_tx` falls after edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `full` and `empty` are registered-equivalent: they are derived from `count` and valid in the cycle after the write.
- At full with a simultaneous pop, the write is accepted, `count` stays at `DEPTH` and `overflow` is not set.

## Structure
- Shared package gets: the state enum (IDLE/START/DATA/STOP), `UART_ADDR`, and the default `CLKS_PER_BIT` constant.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH), with ports `wr_en`, `rd_en`, `wr_data`, `rd_data`, `count`, `full`, `empty`. `rd_data` is the head entry, combinational from the memory array.
- The top level of this block contains the FSM, baud counter, bit counter, shift register and overflow flag.

## Test plan
All tests use `CLKS_PER_BIT`=4 and `DEPTH`=4.
- Reset: hold `rst` 3 cycles → `uart_tx`=1, `empty`=1, `count`=0, `busy`=0, `overflow`=0.
- Single byte: write 0x55 → `uart_tx` falls one cycle after the write edge. The line then reads 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles. After 40 cycles `busy`=0 and `empty`=1.
- Back-to-back: write 0xA3, then 0x0F on the next cycle → two 40-cycle frames with no gap. Decoded bytes are 0xA3 then 0x0F.
- Overflow: write 6 bytes on consecutive cycles starting while IDLE. The first is popped, 4 are queued, `full`=1, and the 6th is dropped with `overflow`=1. Exactly 5 frames follow.
- Write at full with a pop: arrange `count`=4 and write on the cycle STOP→START pops → write accepted, `count` stays 4, `overflow` stays 0.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued → `uart_tx`=1 and `count`=0 after the edge. No further frames follow until a new write.
